// File: rtl/alu_rs_pkg.sv
// Shared ALU reservation station types, tag encoding and the CDB snoop helper.
// Tags are {prefix, root}; load/store roots stop short of 15 so that tagFree stays unallocatable.
package alu_rs_pkg;

    localparam int ENTRIES = 16;
    localparam int ROOT_W  = $clog2(ENTRIES);
    localparam int DATA_W  = 32;
    localparam int TAG_W   = 5;
    localparam int NAME_W  = 5;
    localparam int OP_W    = 6;
    localparam int ADDR_W  = 32;

    typedef logic [DATA_W-1:0] DataBus;
    typedef logic [TAG_W-1:0]  TagBus;
    typedef logic [ROOT_W-1:0] TagRootBus;
    typedef logic [NAME_W-1:0] NameBus;
    typedef logic [OP_W-1:0]   OpBus;
    typedef logic [ADDR_W-1:0] InstAddrBus;

    localparam TagBus tagFree      = 5'b11111;
    localparam logic  ALUtagPrefix = 1'b0;
    localparam logic  LStagPrefix  = 1'b1;
    localparam OpBus  NOP          = 6'd0;
    localparam logic  Enable       = 1'b1;
    localparam logic  Disable      = 1'b0;

    typedef enum logic [1:0] {SLOT_FREE, SLOT_WAIT, SLOT_ISSUED} slot_state_e;

    typedef struct packed {
        TagBus  tag;
        DataBus data;
    } opnd_t;

    typedef struct packed {
        opnd_t      o;
        opnd_t      t;
        TagBus      tag_w;
        NameBus     name_w;
        OpBus       op;
        InstAddrBus addr;
    } rs_entry_t;

    // ALU bus wins if both buses somehow carry the same tag.
    function automatic opnd_t snoop(input opnd_t cur,
                                    input logic en_a, input TagBus tag_a, input DataBus dat_a,
                                    input logic en_l, input TagBus tag_l, input DataBus dat_l);
        opnd_t res;
        res = cur;
        if (cur.tag != tagFree) begin
            if (en_a && cur.tag == tag_a) begin
                res.tag  = tagFree;
                res.data = dat_a;
            end else if (en_l && cur.tag == tag_l) begin
                res.tag  = tagFree;
                res.data = dat_l;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/alu_rs_lowsel.sv
// Priority picker: lowest set request index plus an any-request flag.
// Purely combinational; no backpressure.
module alu_rs_lowsel
    import alu_rs_pkg::*;
#(
    parameter int N = ENTRIES,
    parameter int W = ROOT_W
) (
    input  logic [N-1:0] i_req,
    output logic [W-1:0] o_idx,
    output logic         o_any
);

    always_comb begin
        o_idx = '0;
        o_any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx = W'(i);
                o_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: 16 slots, CDB wakeup, one lowest-index issue per cycle via a single register stage.
// Dispatch-ready instructions bypass into selection; a slot stays held until its own ALU result is broadcast.
module alu_rs
    import alu_rs_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ALUen,
    input  logic [DATA_W-1:0] ALUoperandO,
    input  logic [DATA_W-1:0] ALUoperandT,
    input  logic [TAG_W-1:0]  ALUtagO,
    input  logic [TAG_W-1:0]  ALUtagT,
    input  logic [TAG_W-1:0]  ALUtagW,
    input  logic [NAME_W-1:0] ALUnameW,
    input  logic [OP_W-1:0]   ALUop,
    input  logic [ADDR_W-1:0] ALUaddr,
    input  logic              enCDBALU,
    input  logic [TAG_W-1:0]  CDBALUtag,
    input  logic [DATA_W-1:0] CDBALUdata,
    input  logic              enCDBLS,
    input  logic [TAG_W-1:0]  CDBLStag,
    input  logic [DATA_W-1:0] CDBLSdata,
    output logic [ROOT_W-1:0] ALUfreeTag,
    output logic              ALUfull,
    output logic              issueEn,
    output logic [DATA_W-1:0] issueOperandO,
    output logic [DATA_W-1:0] issueOperandT,
    output logic [TAG_W-1:0]  issueTagW,
    output logic [NAME_W-1:0] issueNameW,
    output logic [OP_W-1:0]   issueOp,
    output logic [ADDR_W-1:0] issueAddr
);

    slot_state_e        r_state [ENTRIES];
    rs_entry_t          r_ent   [ENTRIES];
    rs_entry_t          r_iss;
    logic               r_iss_en;

    logic [ENTRIES-1:0] w_free_req;
    logic [ENTRIES-1:0] w_rdy_req;
    TagRootBus          w_free_idx;
    TagRootBus          w_iss_idx;
    logic               w_free_any;
    logic               w_rdy_any;
    logic               w_disp;
    logic               w_in_rdy;
    rs_entry_t          w_in;
    rs_entry_t          w_iss_ent;

    assign w_disp     = ALUen & w_free_any;
    assign ALUfull    = ~w_free_any;
    assign ALUfreeTag = w_free_idx;

    always_comb begin
        w_in.o      = snoop('{tag: ALUtagO, data: ALUoperandO}, enCDBALU, CDBALUtag, CDBALUdata,
                            enCDBLS, CDBLStag, CDBLSdata);
        w_in.t      = snoop('{tag: ALUtagT, data: ALUoperandT}, enCDBALU, CDBALUtag, CDBALUdata,
                            enCDBLS, CDBLStag, CDBLSdata);
        w_in.tag_w  = ALUtagW;
        w_in.name_w = ALUnameW;
        w_in.op     = ALUop;
        w_in.addr   = ALUaddr;
        w_in_rdy    = w_disp && (w_in.o.tag == tagFree) && (w_in.t.tag == tagFree);
    end

    // The slot being filled is FREE in registered state, so its ready bit comes only from the bypass term.
    always_comb begin
        w_free_req = '0;
        w_rdy_req  = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            w_free_req[i] = (r_state[i] == SLOT_FREE);
            w_rdy_req[i]  = ((r_state[i] == SLOT_WAIT) && (r_ent[i].o.tag == tagFree)
                             && (r_ent[i].t.tag == tagFree))
                            || (w_in_rdy && (w_free_idx == TagRootBus'(i)));
        end
    end

    alu_rs_lowsel u_free_sel (
        .i_req (w_free_req),
        .o_idx (w_free_idx),
        .o_any (w_free_any)
    );

    alu_rs_lowsel u_issue_sel (
        .i_req (w_rdy_req),
        .o_idx (w_iss_idx),
        .o_any (w_rdy_any)
    );

    assign w_iss_ent = (w_in_rdy && (w_iss_idx == w_free_idx)) ? w_in : r_ent[w_iss_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_state[i]     <= SLOT_FREE;
                r_ent[i].o.tag <= tagFree;
                r_ent[i].t.tag <= tagFree;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                case (r_state[i])
                    SLOT_FREE: begin
                        if (w_disp && (w_free_idx == TagRootBus'(i))) begin
                            r_ent[i]   <= w_in;
                            r_state[i] <= (w_rdy_any && (w_iss_idx == TagRootBus'(i)))
                                          ? SLOT_ISSUED : SLOT_WAIT;
                        end
                    end
                    SLOT_WAIT: begin
                        r_ent[i].o <= snoop(r_ent[i].o, enCDBALU, CDBALUtag, CDBALUdata,
                                            enCDBLS, CDBLStag, CDBLSdata);
                        r_ent[i].t <= snoop(r_ent[i].t, enCDBALU, CDBALUtag, CDBALUdata,
                                            enCDBLS, CDBLStag, CDBLSdata);
                        if (w_rdy_any && (w_iss_idx == TagRootBus'(i))) begin
                            r_state[i] <= SLOT_ISSUED;
                        end
                    end
                    SLOT_ISSUED: begin
                        if (enCDBALU && (CDBALUtag == {ALUtagPrefix, TagRootBus'(i)})) begin
                            r_state[i] <= SLOT_FREE;
                        end
                    end
                    default: r_state[i] <= SLOT_FREE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_iss_en    <= Disable;
            r_iss       <= '0;
            r_iss.tag_w <= tagFree;
            r_iss.op    <= NOP;
        end else begin
            r_iss_en <= w_rdy_any ? Enable : Disable;
            if (w_rdy_any) begin
                r_iss <= w_iss_ent;
            end
        end
    end

    assign issueEn       = r_iss_en;
    assign issueOperandO = r_iss.o.data;
    assign issueOperandT = r_iss.t.data;
    assign issueTagW     = r_iss.tag_w;
    assign issueNameW    = r_iss.name_w;
    assign issueOp       = r_iss.op;
    assign issueAddr     = r_iss.addr;

endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs: dispatch/issue latency, CDB wakeup and forwarding, full/free, priority, reset.
module tb_alu_rs;

    logic        clk = 1'b0;
    logic        rst;
    logic        ALUen;
    logic [31:0] ALUoperandO, ALUoperandT, ALUaddr;
    logic [4:0]  ALUtagO, ALUtagT, ALUtagW, ALUnameW;
    logic [5:0]  ALUop;
    logic        enCDBALU, enCDBLS;
    logic [4:0]  CDBALUtag, CDBLStag;
    logic [31:0] CDBALUdata, CDBLSdata;
    logic [3:0]  ALUfreeTag;
    logic        ALUfull, issueEn;
    logic [31:0] issueOperandO, issueOperandT, issueAddr;
    logic [4:0]  issueTagW, issueNameW;
    logic [5:0]  issueOp;

    int checks = 0;
    int errors = 0;

    localparam logic [4:0] TFREE = 5'h1F;

    alu_rs dut (
        .clk(clk), .rst(rst), .ALUen(ALUen),
        .ALUoperandO(ALUoperandO), .ALUoperandT(ALUoperandT),
        .ALUtagO(ALUtagO), .ALUtagT(ALUtagT), .ALUtagW(ALUtagW), .ALUnameW(ALUnameW),
        .ALUop(ALUop), .ALUaddr(ALUaddr),
        .enCDBALU(enCDBALU), .CDBALUtag(CDBALUtag), .CDBALUdata(CDBALUdata),
        .enCDBLS(enCDBLS), .CDBLStag(CDBLStag), .CDBLSdata(CDBLSdata),
        .ALUfreeTag(ALUfreeTag), .ALUfull(ALUfull), .issueEn(issueEn),
        .issueOperandO(issueOperandO), .issueOperandT(issueOperandT),
        .issueTagW(issueTagW), .issueNameW(issueNameW), .issueOp(issueOp), .issueAddr(issueAddr)
    );

    always #5 clk = ~clk;

    // Dispatching into a full station is a protocol error on the bench side.
    always @(negedge clk) begin
        if (!rst && ALUen && ALUfull) begin
            errors++;
            $display("FAIL protocol_dispatch_when_full: ALUen=1 ALUfull=1 required ALUfull=0");
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ALUen = 1'b0; ALUoperandO = '0; ALUoperandT = '0; ALUtagO = TFREE; ALUtagT = TFREE;
        ALUtagW = TFREE; ALUnameW = '0; ALUop = '0; ALUaddr = '0;
        enCDBALU = 1'b0; CDBALUtag = '0; CDBALUdata = '0;
        enCDBLS = 1'b0; CDBLStag = '0; CDBLSdata = '0;
    endtask

    task automatic disp(input logic [4:0] tago, input logic [31:0] opo,
                        input logic [4:0] tagt, input logic [31:0] opt,
                        input logic [3:0] root, input logic [5:0] op);
        ALUen = 1'b1; ALUtagO = tago; ALUoperandO = opo; ALUtagT = tagt; ALUoperandT = opt;
        ALUtagW = {1'b0, root}; ALUnameW = {1'b0, root} + 5'd1; ALUop = op;
        ALUaddr = 32'h1000 + {28'd0, root} * 4;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (issueEn !== 1'b0) begin errors++; $display("FAIL reset_issueEn: got %0b required 0", issueEn); end
        checks++; if (issueOperandO !== 32'h0) begin errors++; $display("FAIL reset_opO: got %h required 0", issueOperandO); end
        checks++; if (issueTagW !== TFREE) begin errors++; $display("FAIL reset_tagW: got %h required %h", issueTagW, TFREE); end
        checks++; if (issueOp !== 6'd0) begin errors++; $display("FAIL reset_op: got %h required 0", issueOp); end
        checks++; if (ALUfreeTag !== 4'd0) begin errors++; $display("FAIL reset_freeTag: got %0d required 0", ALUfreeTag); end
        checks++; if (ALUfull !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b required 0", ALUfull); end
    endtask

    task automatic test_dispatch_ready();
        do_reset();
        disp(TFREE, 32'd5, TFREE, 32'd7, 4'd0, 6'h21);
        checks++; if (ALUfreeTag !== 4'd0) begin errors++; $display("FAIL dr_freeTag_before: got %0d required 0", ALUfreeTag); end
        tick();
        idle();
        checks++; if (issueEn !== 1'b1) begin errors++; $display("FAIL dr_issueEn: got %0b required 1", issueEn); end
        checks++; if (issueOperandO !== 32'd5) begin errors++; $display("FAIL dr_opO: got %0d required 5", issueOperandO); end
        checks++; if (issueOperandT !== 32'd7) begin errors++; $display("FAIL dr_opT: got %0d required 7", issueOperandT); end
        checks++; if (issueTagW !== 5'h00) begin errors++; $display("FAIL dr_tagW: got %h required 00", issueTagW); end
        checks++; if (issueNameW !== 5'd1) begin errors++; $display("FAIL dr_nameW: got %0d required 1", issueNameW); end
        checks++; if (issueOp !== 6'h21) begin errors++; $display("FAIL dr_op: got %h required 21", issueOp); end
        checks++; if (issueAddr !== 32'h1000) begin errors++; $display("FAIL dr_addr: got %h required 1000", issueAddr); end
        checks++; if (ALUfreeTag !== 4'd1) begin errors++; $display("FAIL dr_freeTag_after: got %0d required 1", ALUfreeTag); end
        tick();
        checks++; if (issueEn !== 1'b0) begin errors++; $display("FAIL dr_issueEn_drop: got %0b required 0", issueEn); end
        checks++; if (issueOperandO !== 32'd5) begin errors++; $display("FAIL dr_opO_hold: got %0d required 5", issueOperandO); end
    endtask

    task automatic test_cdb_wakeup();
        do_reset();
        disp(5'h13, 32'hDEAD, TFREE, 32'h22, 4'd0, 6'h05);
        tick();
        idle();
        checks++; if (issueEn !== 1'b0) begin errors++; $display("FAIL wk_blocked_1: got %0b required 0", issueEn); end
        tick();
        enCDBLS = 1'b1; CDBLStag = 5'h13; CDBLSdata = 32'h1234;
        checks++; if (issueEn !== 1'b0) begin errors++; $display("FAIL wk_blocked_2: got %0b required 0", issueEn); end
        tick();
        idle();
        checks++; if (issueEn !== 1'b0) begin errors++; $display("FAIL wk_not_yet: got %0b required 0", issueEn); end
        tick();
        checks++; if (issueEn !== 1'b1) begin errors++; $display("FAIL wk_issueEn: got %0b required 1", issueEn); end
        checks++; if (issueOperandO !== 32'h1234) begin errors++; $display("FAIL wk_opO: got %h required 1234", issueOperandO); end
        checks++; if (issueOperandT !== 32'h22) begin errors++; $display("FAIL wk_opT: got %h required 22", issueOperandT); end
    endtask

    task automatic test_dispatch_forward();
        do_reset();
        disp(TFREE, 32'd1, 5'h02, 32'hBAD, 4'd0, 6'h07);
        enCDBALU = 1'b1; CDBALUtag = 5'h02; CDBALUdata = 32'd9;
        tick();
        idle();
        checks++; if (issueEn !== 1'b1) begin errors++; $display("FAIL fw_issueEn: got %0b required 1", issueEn); end
        checks++; if (issueOperandT !== 32'd9) begin errors++; $display("FAIL fw_opT: got %h required 9", issueOperandT); end
        checks++; if (issueOperandO !== 32'd1) begin errors++; $display("FAIL fw_opO: got %h required 1", issueOperandO); end
    endtask

    task automatic test_full_and_free();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            if (i == 5) disp(TFREE, 32'd50, TFREE, 32'd51, 4'(i), 6'h11);
            else        disp(5'h17, 32'd0, TFREE, 32'd0, 4'(i), 6'h11);
            checks++; if (ALUfreeTag !== 4'(i)) begin errors++; $display("FAIL fill_freeTag_%0d: got %0d required %0d", i, ALUfreeTag, i); end
            tick();
            if (i == 5) begin
                checks++; if (issueEn !== 1'b1 || issueTagW !== 5'h05) begin errors++; $display("FAIL fill_issue5: got en=%0b tag=%h required en=1 tag=05", issueEn, issueTagW); end
            end
        end
        idle();
        checks++; if (ALUfull !== 1'b1) begin errors++; $display("FAIL full_flag: got %0b required 1", ALUfull); end
        checks++; if (ALUfreeTag !== 4'd0) begin errors++; $display("FAIL full_freeTag: got %0d required 0", ALUfreeTag); end
        enCDBALU = 1'b1; CDBALUtag = 5'h03; CDBALUdata = 32'd0;
        tick();
        idle();
        checks++; if (ALUfull !== 1'b1) begin errors++; $display("FAIL wait_slot_not_freed: got %0b required 1", ALUfull); end
        enCDBALU = 1'b1; CDBALUtag = 5'h05; CDBALUdata = 32'd0;
        checks++; if (ALUfull !== 1'b1) begin errors++; $display("FAIL free_same_cycle: got %0b required 1", ALUfull); end
        tick();
        idle();
        checks++; if (ALUfull !== 1'b0) begin errors++; $display("FAIL freed_full: got %0b required 0", ALUfull); end
        checks++; if (ALUfreeTag !== 4'd5) begin errors++; $display("FAIL freed_freeTag: got %0d required 5", ALUfreeTag); end
    endtask

    task automatic test_priority();
        do_reset();
        disp(5'h1E, 32'd0, TFREE, 32'd0, 4'd0, 6'h01); tick();
        disp(5'h11, 32'd0, TFREE, 32'h10, 4'd1, 6'h01); tick();
        disp(5'h1E, 32'd0, TFREE, 32'd0, 4'd2, 6'h01); tick();
        disp(TFREE, 32'h30, 5'h11, 32'd0, 4'd3, 6'h01); tick();
        idle();
        enCDBLS = 1'b1; CDBLStag = 5'h11; CDBLSdata = 32'hAA;
        tick();
        idle();
        checks++; if (issueEn !== 1'b0) begin errors++; $display("FAIL pr_not_yet: got %0b required 0", issueEn); end
        tick();
        checks++; if (issueEn !== 1'b1 || issueTagW !== 5'h01) begin errors++; $display("FAIL pr_first: got en=%0b tag=%h required en=1 tag=01", issueEn, issueTagW); end
        checks++; if (issueOperandO !== 32'hAA) begin errors++; $display("FAIL pr_first_opO: got %h required aa", issueOperandO); end
        tick();
        checks++; if (issueEn !== 1'b1 || issueTagW !== 5'h03) begin errors++; $display("FAIL pr_second: got en=%0b tag=%h required en=1 tag=03", issueEn, issueTagW); end
        checks++; if (issueOperandT !== 32'hAA) begin errors++; $display("FAIL pr_second_opT: got %h required aa", issueOperandT); end
        tick();
        checks++; if (issueEn !== 1'b0) begin errors++; $display("FAIL pr_drain: got %0b required 0", issueEn); end
    endtask

    task automatic test_reset_midop();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i < 2) disp(TFREE, 32'd1, TFREE, 32'd2, 4'(i), 6'h02);
            else       disp(5'h13, 32'd0, TFREE, 32'd0, 4'(i), 6'h02);
            tick();
        end
        idle();
        checks++; if (ALUfreeTag !== 4'd6) begin errors++; $display("FAIL mid_pre_freeTag: got %0d required 6", ALUfreeTag); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (ALUfull !== 1'b0) begin errors++; $display("FAIL mid_full: got %0b required 0", ALUfull); end
        checks++; if (ALUfreeTag !== 4'd0) begin errors++; $display("FAIL mid_freeTag: got %0d required 0", ALUfreeTag); end
        checks++; if (issueEn !== 1'b0) begin errors++; $display("FAIL mid_issueEn: got %0b required 0", issueEn); end
        enCDBLS = 1'b1; CDBLStag = 5'h13; CDBLSdata = 32'h77;
        enCDBALU = 1'b1; CDBALUtag = 5'h00; CDBALUdata = 32'h0;
        tick();
        idle();
        checks++; if (issueEn !== 1'b0) begin errors++; $display("FAIL mid_no_issue_1: got %0b required 0", issueEn); end
        tick();
        checks++; if (issueEn !== 1'b0) begin errors++; $display("FAIL mid_no_issue_2: got %0b required 0", issueEn); end
        checks++; if (ALUfreeTag !== 4'd0) begin errors++; $display("FAIL mid_freeTag_after: got %0d required 0", ALUfreeTag); end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_dispatch_ready();
        test_cdb_wakeup();
        test_dispatch_forward();
        test_full_and_free();
        test_priority();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_rs.md
# alu_rs

ALU reservation station: the receiving end of the dispatcher's ALU port. Holds up to 16 renamed ALU-class instructions (LUI, AUIPC, JAL, JALR, RI, RR), snoops the two CDB result buses to resolve pending source tags, and issues one ready instruction per cycle to the ALU. Slot index is the tag root: it supplies the free root the dispatcher prefixes to form the destination tag, and a slot is not reused until its own result is broadcast.

## Interface
- ENTRIES, 16: number of slots; tag root width = log2(ENTRIES) = 4.
- clk  in  1  clock.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- ALUen  in  1  dispatch valid this cycle.
- ALUoperandO / ALUoperandT  in  32 each  source values (valid when the matching tag is tagFree).
- ALUtagO / ALUtagT  in  5 each  source tags; tagFree = value ready.
- ALUtagW  in  5  destination tag; low 4 bits equal ALUfreeTag.
- ALUnameW  in  5  destination register name.
- ALUop  in  6  opcode.
- ALUaddr  in  32  instruction address.
- enCDBALU, CDBALUtag[5], CDBALUdata[32]  in  ALU result broadcast.
- enCDBLS, CDBLStag[5], CDBLSdata[32]  in  load result broadcast.
- ALUfreeTag  out  4  lowest-index FREE slot (combinational); 0 when full.
- ALUfull  out  1  no FREE slot (combinational).
- issueEn  out  1  registered; issue valid.
- issueOperandO / issueOperandT  out  32 each.
- issueTagW  out  5; issueNameW  out  5; issueOp  out  6; issueAddr  out  32.

## Operation
- Per-slot state: FREE -> WAIT (dispatch) -> ISSUED (selected) -> FREE (enCDBALU with CDBALUtag == {ALU prefix, slot}).
- Dispatch: when ALUen, slot ALUfreeTag captures all fields, state WAIT. ALUen while ALUfull is a protocol error: ignored, no state change (bench asserts it never happens).
- Dispatch-cycle forwarding: if an incoming source tag matches a valid CDB tag in the same cycle, store that CDB data and tagFree for that operand.
- Wakeup: every WAIT slot compares both stored tags against both CDBs each cycle; match -> store data, set tag to tagFree. Both operands may wake in one cycle, from either bus.
- Ready = WAIT and both tags tagFree (using registered slot state). Select lowest-index ready slot; register its fields onto issue outputs with issueEn=1; slot -> ISSUED. None ready -> issueEn=0, other issue outputs hold.
- Free on own broadcast only; a CDB tag matching a WAIT/FREE slot's index does nothing to that slot's state.
- Width rules: data passed unmodified, no arithmetic here.

## Timing
- Reset: all slots FREE, stored tags tagFree; issueEn=0, issue data/addr 0, issueTagW tagFree, issueNameW 0, issueOp NOP; ALUfreeTag=0, ALUfull=0. Reset mid-operation discards all slots, including ISSUED.
- Dispatch with ready operands in cycle t -> issueEn=1 in cycle t+1 (single registered stage).
- CDB wakeup in cycle t -> slot eligible for selection in t+1 -> issueEn in t+2.
- Slot freed by broadcast in cycle t -> visible in ALUfreeTag in t+1; not reallocatable in t.
- Simultaneous dispatch + wakeup + issue + free in one cycle: all legal and independent (distinct slots by construction).
- Throughput: one issue per cycle.

## Structure
- Shared defines (existing header): DataBus, TagBus, TagRootBus, NameBus, OpBus, InstAddrBus, tagFree, ALUtagPrefix, LStagPrefix, NOP, Enable/Disable; tagFree never equals any allocatable tag.
- One sub-module: alu_rs_lowsel — 16-bit request vector -> lowest set index + any flag; instantiated twice (free slot, ready slot).

## Test plan
- Reset then dispatch RR op, tags tagFree, operands 5/7, in cycle 1 -> issueEn=1 cycle 2, operands 5/7, issueTagW={ALU,0}; ALUfreeTag becomes 1.
- Dispatch with ALUtagO={LS,3}; CDB LS broadcasts tag {LS,3} data 0x1234 two cycles later -> issue two cycles after broadcast with issueOperandO=0x1234.
- Dispatch with ALUtagT={ALU,2} while enCDBALU broadcasts {ALU,2} data 9 same cycle -> issue next cycle with operandT=9.
- Fill 16 slots with blocked operands -> ALUfull=1; broadcast own tag of slot 5 only after it issued -> ALUfull=0, ALUfreeTag=5 next cycle.
- Slots 1 and 3 become ready same cycle -> slot 1 issues first, slot 3 next cycle.
- Assert rst with 4 WAIT and 2 ISSUED slots -> next cycle ALUfull=0, ALUfreeTag=0, issueEn=0, later broadcasts cause no issue.
